// File: rtl/ascii_dec_parser.sv
// ascii_dec_parser: decodes decimal ASCII text ("0".."255" plus a CR/LF/space
// terminator) into one byte and hands it to a UART transmitter through a
// one-deep pending buffer.
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous active-high reset
//   char_in_i      received character, sampled when char_valid_i is high
//   char_valid_i   single-cycle character strobe (uart_rx rx_done_tick)
//   tx_done_i      single-cycle transmit-complete strobe (uart_tx tx_done_tick)
//   tx_start_o     single-cycle transmit request
//   tx_data_o      byte to transmit, stable from tx_start_o until tx_done_i
//   value_o        last successfully decoded value
//   value_valid_o  single-cycle pulse when value_o updates
//   err_o          single-cycle pulse on parse error or transmit overrun
//   busy_o         high from tx_start_o up to and including tx_done_i
module ascii_dec_parser #(
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] char_in_i,
  input  logic       char_valid_i,
  input  logic       tx_done_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic [7:0] value_o,
  output logic       value_valid_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDiscard} parse_state_e;
  typedef enum logic {TxIdle, TxWait} tx_state_e;

  parse_state_e state_q, state_d;
  tx_state_e    tx_state_q, tx_state_d;

  logic [9:0]      acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      pend_data_q, pend_data_d;
  logic            pend_full_q, pend_full_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      value_q, value_d;
  logic            value_valid_q, value_valid_d;
  logic            err_q, err_d;

  logic        is_digit, is_term;
  logic [3:0]  digit_val;
  logic [13:0] acc_mul;
  logic        submit, parse_err, overrun;

  assign is_digit  = (char_in_i >= 8'h30) && (char_in_i <= 8'h39);
  assign is_term   = (char_in_i == 8'h0D) || (char_in_i == 8'h0A) || (char_in_i == 8'h20);
  assign digit_val = char_in_i[3:0];
  assign acc_mul   = 14'(acc_q) * 14'd10 + 14'(digit_val);

  // Parse FSM
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    parse_err = 1'b0;
    submit    = 1'b0;
    if (char_valid_i) begin
      unique case (state_q)
        StIdle: begin
          if (is_digit) begin
            acc_d   = 10'(digit_val);
            cnt_d   = CntW'(1);
            state_d = StAccum;
          end else if (!is_term) begin
            parse_err = 1'b1;
            state_d   = StDiscard;
          end
        end
        StAccum: begin
          if (is_digit) begin
            if (32'(cnt_q) < MAX_DIGITS) begin
              // Saturate so wide MAX_DIGITS settings cannot wrap back into range.
              acc_d = (acc_mul > 14'd1023) ? 10'h3FF : acc_mul[9:0];
              cnt_d = cnt_q + CntW'(1);
            end else begin
              parse_err = 1'b1;
              state_d   = StDiscard;
            end
          end else if (is_term) begin
            if (acc_q <= 10'd255) submit = 1'b1;
            else                  parse_err = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            parse_err = 1'b1;
            state_d   = StDiscard;
          end
        end
        StDiscard: begin
          if (is_term) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
        default: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // TX path with one-deep pending buffer
  always_comb begin
    tx_state_d  = tx_state_q;
    pend_data_d = pend_data_q;
    pend_full_d = pend_full_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    overrun     = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (submit) begin
          tx_data_d  = acc_q[7:0];
          tx_start_d = 1'b1;
          tx_state_d = TxWait;
        end
      end
      TxWait: begin
        if (tx_done_i) begin
          if (pend_full_q) begin
            tx_data_d  = pend_data_q;
            tx_start_d = 1'b1;
            // A coinciding submit refills the slot being drained.
            if (submit) pend_data_d = acc_q[7:0];
            else        pend_full_d = 1'b0;
          end else if (submit) begin
            tx_data_d  = acc_q[7:0];
            tx_start_d = 1'b1;
          end else begin
            tx_state_d = TxIdle;
          end
        end else if (submit) begin
          if (!pend_full_q) begin
            pend_data_d = acc_q[7:0];
            pend_full_d = 1'b1;
          end else begin
            overrun = 1'b1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign value_d       = submit ? acc_q[7:0] : value_q;
  assign value_valid_d = submit;
  assign err_d         = parse_err | overrun;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      tx_state_q    <= TxIdle;
      acc_q         <= '0;
      cnt_q         <= '0;
      pend_data_q   <= '0;
      pend_full_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_state_q    <= tx_state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      pend_data_q   <= pend_data_d;
      pend_full_q   <= pend_full_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      err_q         <= err_d;
    end
  end

  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign value_o       = value_q;
  assign value_valid_o = value_valid_q;
  assign err_o         = err_q;
  // Transmit is outstanding exactly while the TX FSM waits for tx_done.
  assign busy_o        = (tx_state_q == TxWait);

endmodule

// File: tb/tb_ascii_dec_parser.sv
module tb_ascii_dec_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_start, value_valid, err, busy;
  logic [7:0] tx_data, value;

  int n_chk = 0;
  int n_fail = 0;

  // Pulse monitors sampled mid-cycle.
  int n_vv = 0;
  int n_err = 0;
  logic [7:0] tx_log[$];

  ascii_dec_parser #(.MAX_DIGITS(3)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .char_in_i    (char_in),
    .char_valid_i (char_valid),
    .tx_done_i    (tx_done),
    .tx_start_o   (tx_start),
    .tx_data_o    (tx_data),
    .value_o      (value),
    .value_valid_o(value_valid),
    .err_o        (err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (value_valid) n_vv++;
    if (err) n_err++;
    if (tx_start) tx_log.push_back(tx_data);
  end

  // Character is sampled on the posedge in between; returns at the negedge
  // where the resulting registered outputs are visible.
  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    char_in = c;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    idle(2);
    n_chk++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
    n_chk++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    n_chk++; if (value !== 8'h00) begin n_fail++; $display("FAIL rst_value got %h want 00", value); end
    n_chk++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL rst_vv got %b want 0", value_valid); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send_char("0");
    send_char("6");
    send_char("5");
    n_chk++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_vv got %b want 0", value_valid); end
    send_char(8'h0D);
    n_chk++; if (value_valid !== 1'b1) begin n_fail++; $display("FAIL basic_vv got %b want 1", value_valid); end
    n_chk++; if (value !== 8'h41) begin n_fail++; $display("FAIL basic_value got %h want 41", value); end
    n_chk++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL basic_start got %b want 1", tx_start); end
    n_chk++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL basic_data got %h want 41", tx_data); end
    idle(3);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    n_chk++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL basic_start_hold got %b want 0", tx_start); end
    n_chk++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL basic_data_hold got %h want 41", tx_data); end
    pulse_done();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_two_values();
    int log0 = tx_log.size();
    send_char("2"); send_char("5"); send_char("5");
    send_char(8'h0D);
    n_chk++; if (value !== 8'hFF) begin n_fail++; $display("FAIL two_v1 got %h want ff", value); end
    n_chk++; if (tx_start !== 1'b1 || tx_data !== 8'hFF) begin
      n_fail++; $display("FAIL two_tx1 got %b/%h want 1/ff", tx_start, tx_data); end
    send_char(8'h0A);
    n_chk++; if (value_valid !== 1'b0 || err !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++; $display("FAIL two_lf got vv%b err%b st%b want 000", value_valid, err, tx_start); end
    send_char("0");
    send_char(8'h0D);
    n_chk++; if (value_valid !== 1'b1 || value !== 8'h00) begin
      n_fail++; $display("FAIL two_v2 got %b/%h want 1/00", value_valid, value); end
    n_chk++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL two_pend got %b want 0", tx_start); end
    pulse_done();
    n_chk++; if (tx_start !== 1'b1 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL two_tx2 got %b/%h want 1/00", tx_start, tx_data); end
    pulse_done();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL two_busy got %b want 0", busy); end
    n_chk++; if (tx_log.size() - log0 != 2 || tx_log[log0] !== 8'hFF || tx_log[log0+1] !== 8'h00) begin
      n_fail++; $display("FAIL two_log got %0d entries want 2 (ff,00)", tx_log.size() - log0); end
  endtask

  task automatic test_errors();
    int vv0 = n_vv;
    int er0 = n_err;
    int log0 = tx_log.size();
    send_char("2"); send_char("5"); send_char("6");
    send_char(8'h0D);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_256 got %b want 1", err); end
    send_char("1"); send_char("2"); send_char("3");
    send_char("4");
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_1234 got %b want 1", err); end
    send_char(8'h0D);
    send_char("1");
    send_char("x");
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_1x9 got %b want 1", err); end
    send_char("9");
    send_char(8'h0D);
    idle(2);
    n_chk++; if (n_err - er0 != 3) begin n_fail++; $display("FAIL err_count got %0d want 3", n_err - er0); end
    n_chk++; if (n_vv != vv0) begin n_fail++; $display("FAIL err_vv got %0d want 0", n_vv - vv0); end
    n_chk++; if (tx_log.size() != log0) begin
      n_fail++; $display("FAIL err_tx got %0d want 0", tx_log.size() - log0); end
    n_chk++; if (value !== 8'h00) begin n_fail++; $display("FAIL err_value got %h want 00", value); end
  endtask

  task automatic test_overrun();
    int log0 = tx_log.size();
    send_char("1"); send_char(8'h0D);
    n_chk++; if (tx_start !== 1'b1 || tx_data !== 8'h01) begin
      n_fail++; $display("FAIL ovr_tx1 got %b/%h want 1/01", tx_start, tx_data); end
    send_char("2"); send_char(8'h0D);
    n_chk++; if (tx_start !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL ovr_pend got st%b err%b want 00", tx_start, err); end
    send_char("3"); send_char(8'h0D);
    n_chk++; if (err !== 1'b1 || value !== 8'h03 || value_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovr_err got err%b %h vv%b want 1 03 1", err, value, value_valid); end
    pulse_done();
    n_chk++; if (tx_start !== 1'b1 || tx_data !== 8'h02) begin
      n_fail++; $display("FAIL ovr_tx2 got %b/%h want 1/02", tx_start, tx_data); end
    idle(2);
    pulse_done();
    idle(2);
    n_chk++; if (tx_log.size() - log0 != 2 || tx_log[log0] !== 8'h01 || tx_log[log0+1] !== 8'h02) begin
      n_fail++; $display("FAIL ovr_log got %0d entries want 2 (01,02)", tx_log.size() - log0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_busy got %b want 0", busy); end
  endtask

  task automatic test_coincide();
    send_char("4"); send_char(8'h0D);
    send_char("5"); send_char(8'h0D);
    send_char("6");
    @(negedge clk);
    char_in = 8'h0D; char_valid = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    char_valid = 1'b0; tx_done = 1'b0;
    n_chk++; if (tx_start !== 1'b1 || tx_data !== 8'h05) begin
      n_fail++; $display("FAIL coin_tx got %b/%h want 1/05", tx_start, tx_data); end
    n_chk++; if (err !== 1'b0 || value !== 8'h06) begin
      n_fail++; $display("FAIL coin_state got err%b %h want 0 06", err, value); end
    pulse_done();
    n_chk++; if (tx_start !== 1'b1 || tx_data !== 8'h06) begin
      n_fail++; $display("FAIL coin_tx2 got %b/%h want 1/06", tx_start, tx_data); end
    pulse_done();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coin_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); char_in = "4"; char_valid = 1'b1;
    @(negedge clk); char_in = "2";
    @(negedge clk); char_in = 8'h20;
    @(negedge clk); char_valid = 1'b0;
    n_chk++; if (value_valid !== 1'b1 || value !== 8'h2A) begin
      n_fail++; $display("FAIL b2b_value got %b/%h want 1/2a", value_valid, value); end
    n_chk++; if (tx_start !== 1'b1 || tx_data !== 8'h2A) begin
      n_fail++; $display("FAIL b2b_tx got %b/%h want 1/2a", tx_start, tx_data); end
    pulse_done();
  endtask

  task automatic test_reset_mid();
    send_char("7"); send_char(8'h0D);
    send_char("1"); send_char("2");
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++; if ({tx_start, tx_data, value, value_valid, err, busy} !== 20'h0) begin
      n_fail++; $display("FAIL mid_rst_outs got st%b %h %h vv%b err%b busy%b want all 0",
                         tx_start, tx_data, value, value_valid, err, busy); end
    @(negedge clk);
    reset = 1'b0;
    send_char("9"); send_char(8'h0D);
    n_chk++; if (value_valid !== 1'b1 || value !== 8'h09) begin
      n_fail++; $display("FAIL mid_value got %b/%h want 1/09", value_valid, value); end
    n_chk++; if (tx_start !== 1'b1 || tx_data !== 8'h09 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_tx got %b/%h busy%b want 1/09 1", tx_start, tx_data, busy); end
    pulse_done();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_values();
    test_errors();
    test_overrun();
    test_coincide();
    test_back_to_back();
    test_reset_mid();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
